// File: rtl/w_bram_ctrl_pkg.sv
// Shared definitions for the BRAM ring: geometry and controller state encoding
// (the port-B read-side logic uses the same state values).
package w_bram_ctrl_pkg;

  localparam int BRAM_ADDR_W = 9;
  localparam int BRAM_DEPTH  = 2 ** BRAM_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/w_bram_ctrl_occ_cnt.sv
// Up/down occupancy counter for the BRAM ring with registered full/empty and a
// sticky underflow flag; reads against an empty ring are ignored.
module w_bram_ctrl_occ_cnt
  import w_bram_ctrl_pkg::*;
#(
  parameter int ADDR_W = BRAM_ADDR_W
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            inc,
  input  logic            dec_req,
  output logic [ADDR_W:0] count,
  output logic            full,
  output logic            empty,
  output logic            udf_err
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic            dec;
  logic [ADDR_W:0] count_nxt;

  always_comb begin
    dec       = dec_req && (count != '0);
    count_nxt = count;
    if (inc && !dec) begin
      count_nxt = count + 1'b1;
    end else if (dec && !inc) begin
      count_nxt = count - 1'b1;
    end
  end

  // Flags are computed from the next count so they line up with the count itself.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      udf_err <= 1'b0;
    end else begin
      count <= count_nxt;
      full  <= (count_nxt == DEPTH);
      empty <= (count_nxt == '0);
      if (dec_req && (count == '0)) begin
        udf_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/w_bram_ctrl.sv
// BRAM port-A write controller: valid/ready intake, one-cycle registered write
// port, ring occupancy tracking against the port-B read pulses.
module w_bram_ctrl
  import w_bram_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = BRAM_ADDR_W
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic              drain,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              r_bram_addr_en,
  output logic [ADDR_W-1:0] ADDR_A,
  output logic [DATA_W-1:0] DIN_A,
  output logic              WE_A,
  output logic              EN_A,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              ovf_err,
  output logic              udf_err,
  output logic              done
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic              accept;

  assign s_ready = (state == ST_RUN) && !full;
  assign accept  = s_valid && s_ready;
  assign EN_A    = WE_A;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (drain) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (count == '0) begin
          state_nxt = ST_IDLE;
          done      = 1'b1;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  w_bram_ctrl_occ_cnt #(
    .ADDR_W (ADDR_W)
  ) u_occ (
    .CLK     (CLK),
    .rst     (rst),
    .inc     (accept),
    .dec_req (r_bram_addr_en),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .udf_err (udf_err)
  );

  // ADDR_A/DIN_A hold their last value between writes; only WE_A qualifies them.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      ADDR_A  <= '0;
      DIN_A   <= '0;
      WE_A    <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      WE_A <= accept;
      if (accept) begin
        ADDR_A <= wr_ptr;
        DIN_A  <= s_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if ((state == ST_RUN) && full && s_valid) begin
        ovf_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_w_bram_ctrl.sv
// Self-checking bench for w_bram_ctrl: directed scenarios plus a randomized run,
// all compared against a cycle-level behavioural model of the ring.
module tb_w_bram_ctrl;

  localparam int DEPTH   = 512;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        drain = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        r_bram_addr_en = 1'b0;
  logic        s_ready;
  logic [8:0]  ADDR_A;
  logic [15:0] DIN_A;
  logic        WE_A;
  logic        EN_A;
  logic [9:0]  count;
  logic        full;
  logic        empty;
  logic        ovf_err;
  logic        udf_err;
  logic        done;

  int          passed = 0;
  int          total  = 0;

  int          m_state;
  int          m_count;
  int          m_wptr;
  int          m_addr;
  logic [15:0] m_din;
  logic        m_we;
  logic        m_ovf;
  logic        m_udf;
  logic        obs_ready;
  logic        obs_done;
  logic        exp_ready;
  logic        exp_done;

  w_bram_ctrl dut (
    .CLK            (CLK),
    .rst            (rst),
    .start          (start),
    .drain          (drain),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .r_bram_addr_en (r_bram_addr_en),
    .ADDR_A         (ADDR_A),
    .DIN_A          (DIN_A),
    .WE_A           (WE_A),
    .EN_A           (EN_A),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .ovf_err        (ovf_err),
    .udf_err        (udf_err),
    .done           (done)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_state = M_IDLE;
    m_count = 0;
    m_wptr  = 0;
    m_addr  = 0;
    m_din   = '0;
    m_we    = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    rst = 1'b1;
    start = 1'b0; drain = 1'b0; s_valid = 1'b0; r_bram_addr_en = 1'b0; s_data = '0;
    model_reset();
    @(negedge CLK);
    rst = 1'b0;
  endtask

  // One clock: drive inputs mid-cycle, record combinational outputs, advance the model at the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic rd,
                      input logic st, input logic dr);
    bit acc;
    @(negedge CLK);
    s_valid = v; s_data = d; r_bram_addr_en = rd; start = st; drain = dr;
    #1;
    obs_ready = s_ready;
    obs_done  = done;
    exp_ready = (m_state == M_RUN) && (m_count < DEPTH);
    exp_done  = (m_state == M_DRAIN) && (m_count == 0);
    acc = v && exp_ready;
    @(posedge CLK);
    if (m_state == M_RUN && m_count == DEPTH && v) m_ovf = 1'b1;
    if (rd && m_count == 0) m_udf = 1'b1;
    case (m_state)
      M_IDLE:  if (st) m_state = M_RUN;
      M_RUN:   if (dr) m_state = M_DRAIN;
      default: if (m_count == 0) m_state = M_IDLE;
    endcase
    m_count = m_count + (acc ? 1 : 0) - ((rd && m_count > 0) ? 1 : 0);
    m_we = acc;
    if (acc) begin
      m_addr = m_wptr;
      m_din  = d;
      m_wptr = (m_wptr + 1) % DEPTH;
    end
    #1;
    s_valid = 1'b0; r_bram_addr_en = 1'b0; start = 1'b0; drain = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (WE_A !== 1'b0) $display("[TB] FAIL reset_we: got %b expected 0", WE_A); else passed++;
    total++; if (EN_A !== 1'b0) $display("[TB] FAIL reset_en: got %b expected 0", EN_A); else passed++;
    total++; if (ADDR_A !== 9'd0) $display("[TB] FAIL reset_addr: got %0d expected 0", ADDR_A); else passed++;
    total++; if (DIN_A !== 16'd0) $display("[TB] FAIL reset_din: got %h expected 0", DIN_A); else passed++;
    total++; if (count !== 10'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count); else passed++;
    total++; if (empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b expected 1", empty); else passed++;
    total++; if (full !== 1'b0) $display("[TB] FAIL reset_full: got %b expected 0", full); else passed++;
    total++; if (s_ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", s_ready); else passed++;
    total++; if ({ovf_err, udf_err, done} !== 3'b000) $display("[TB] FAIL reset_flags: got %b expected 000", {ovf_err, udf_err, done}); else passed++;
  endtask

  task automatic test_basic_write();
    logic [15:0] words [3];
    words[0] = 16'h00A1; words[1] = 16'h00A2; words[2] = 16'h00A3;
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, words[i], 1'b0, 1'b0, 1'b0);
      total++; if (obs_ready !== 1'b1) $display("[TB] FAIL basic_ready%0d: got %b expected 1", i, obs_ready); else passed++;
      total++; if ({WE_A, EN_A} !== 2'b11) $display("[TB] FAIL basic_we%0d: got %b expected 11", i, {WE_A, EN_A}); else passed++;
      total++; if (ADDR_A !== 9'(i)) $display("[TB] FAIL basic_addr%0d: got %0d expected %0d", i, ADDR_A, i); else passed++;
      total++; if (DIN_A !== words[i]) $display("[TB] FAIL basic_din%0d: got %h expected %h", i, DIN_A, words[i]); else passed++;
      total++; if (count !== 10'(i + 1)) $display("[TB] FAIL basic_count%0d: got %0d expected %0d", i, count, i + 1); else passed++;
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    total++; if (WE_A !== 1'b0) $display("[TB] FAIL basic_idle_we: got %b expected 0", WE_A); else passed++;
    total++; if (count !== 10'd3) $display("[TB] FAIL basic_final_count: got %0d expected 3", count); else passed++;
  endtask

  task automatic test_full_overflow();
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
      total++;
      if (WE_A !== 1'b1 || ADDR_A !== 9'(m_addr) || DIN_A !== m_din)
        $display("[TB] FAIL full_write%0d: got we=%b addr=%0d din=%h expected we=1 addr=%0d din=%h",
                 i, WE_A, ADDR_A, DIN_A, m_addr, m_din);
      else passed++;
    end
    total++; if (count !== 10'd512) $display("[TB] FAIL full_count: got %0d expected 512", count); else passed++;
    total++; if ({full, empty} !== 2'b10) $display("[TB] FAIL full_flags: got full/empty=%b expected 10", {full, empty}); else passed++;
    total++; if (ovf_err !== 1'b0) $display("[TB] FAIL full_ovf_early: got %b expected 0", ovf_err); else passed++;
    step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
    total++; if (obs_ready !== 1'b0) $display("[TB] FAIL full_ready: got %b expected 0", obs_ready); else passed++;
    total++; if (WE_A !== 1'b0) $display("[TB] FAIL full_no_write: got %b expected 0", WE_A); else passed++;
    total++; if (ovf_err !== 1'b1) $display("[TB] FAIL full_ovf: got %b expected 1", ovf_err); else passed++;
    total++; if (count !== 10'd512) $display("[TB] FAIL full_count_hold: got %0d expected 512", count); else passed++;
  endtask

  task automatic test_wrap();
    logic [15:0] d;
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++; if (count !== 10'd0) $display("[TB] FAIL wrap_pre_count: got %0d expected 0", count); else passed++;
    d = 16'($urandom);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
    total++; if (WE_A !== 1'b1 || ADDR_A !== 9'd511 || DIN_A !== d) $display("[TB] FAIL wrap_addr511: got we=%b addr=%0d din=%h expected we=1 addr=511 din=%h", WE_A, ADDR_A, DIN_A, d); else passed++;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++; if (WE_A !== 1'b0 || count !== 10'd0) $display("[TB] FAIL wrap_read: got we=%b count=%0d expected we=0 count=0", WE_A, count); else passed++;
    d = 16'($urandom);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
    total++; if (WE_A !== 1'b1 || ADDR_A !== 9'd0 || DIN_A !== d) $display("[TB] FAIL wrap_addr0: got we=%b addr=%0d din=%h expected we=1 addr=0 din=%h", WE_A, ADDR_A, DIN_A, d); else passed++;
    step(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
    total++; if (ADDR_A !== 9'd1 || count !== 10'd1) $display("[TB] FAIL wrap_addr1: got addr=%0d count=%0d expected addr=1 count=1", ADDR_A, count); else passed++;
    total++; if (udf_err !== 1'b0) $display("[TB] FAIL wrap_udf: got %b expected 0", udf_err); else passed++;
  endtask

  task automatic test_same_cycle_and_underflow();
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    total++; if (count !== 10'd5) $display("[TB] FAIL same_cycle_count: got %0d expected 5", count); else passed++;
    total++; if (WE_A !== 1'b1 || ADDR_A !== 9'd5) $display("[TB] FAIL same_cycle_write: got we=%b addr=%0d expected we=1 addr=5", WE_A, ADDR_A); else passed++;
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++; if (count !== 10'd0 || empty !== 1'b1) $display("[TB] FAIL drained_count: got count=%0d empty=%b expected 0 1", count, empty); else passed++;
    total++; if (udf_err !== 1'b0) $display("[TB] FAIL udf_early: got %b expected 0", udf_err); else passed++;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    total++; if (udf_err !== 1'b1) $display("[TB] FAIL udf_set: got %b expected 1", udf_err); else passed++;
    total++; if (count !== 10'd0) $display("[TB] FAIL udf_count: got %0d expected 0", count); else passed++;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    total++; if (udf_err !== 1'b1) $display("[TB] FAIL udf_sticky: got %b expected 1", udf_err); else passed++;
  endtask

  task automatic test_drain();
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0C0D, 1'b0, 1'b0, 1'b1);
    total++; if (WE_A !== 1'b1 || ADDR_A !== 9'd3 || DIN_A !== 16'h0C0D) $display("[TB] FAIL drain_pending: got we=%b addr=%0d din=%h expected 1 3 0c0d", WE_A, ADDR_A, DIN_A); else passed++;
    step(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
    total++; if (obs_ready !== 1'b0) $display("[TB] FAIL drain_ready: got %b expected 0", obs_ready); else passed++;
    total++; if (WE_A !== 1'b0 || count !== 10'd4) $display("[TB] FAIL drain_hold: got we=%b count=%0d expected 0 4", WE_A, count); else passed++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      total++; if (obs_done !== 1'b0) $display("[TB] FAIL drain_done_early%0d: got %b expected 0", i, obs_done); else passed++;
    end
    total++; if (count !== 10'd0) $display("[TB] FAIL drain_count: got %0d expected 0", count); else passed++;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    total++; if (obs_done !== 1'b1) $display("[TB] FAIL drain_done: got %b expected 1", obs_done); else passed++;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    total++; if (obs_done !== 1'b0 || obs_ready !== 1'b0) $display("[TB] FAIL drain_idle: got done=%b ready=%b expected 0 0", obs_done, obs_ready); else passed++;
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    total++; if (obs_ready !== 1'b0) $display("[TB] FAIL idle_drain_ignored: got ready=%b expected 0", obs_ready); else passed++;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    total++; if (obs_ready !== 1'b1) $display("[TB] FAIL restart_ready: got %b expected 1", obs_ready); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    total++; if (count !== 10'd100 || WE_A !== 1'b1) $display("[TB] FAIL mid_pre: got count=%0d we=%b expected 100 1", count, WE_A); else passed++;
    s_valid = 1'b1;
    rst = 1'b1;
    #1;
    total++; if (WE_A !== 1'b0 || EN_A !== 1'b0) $display("[TB] FAIL mid_we: got we=%b en=%b expected 0 0", WE_A, EN_A); else passed++;
    total++; if (count !== 10'd0 || empty !== 1'b1 || full !== 1'b0) $display("[TB] FAIL mid_count: got count=%0d empty=%b full=%b expected 0 1 0", count, empty, full); else passed++;
    total++; if (ADDR_A !== 9'd0 || DIN_A !== 16'd0 || s_ready !== 1'b0) $display("[TB] FAIL mid_port: got addr=%0d din=%h ready=%b expected 0 0 0", ADDR_A, DIN_A, s_ready); else passed++;
    s_valid = 1'b0;
    model_reset();
    @(negedge CLK);
    rst = 1'b0;
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
      errs = 0;
      if (obs_ready !== exp_ready || obs_done !== exp_done) errs++;
      if (WE_A !== m_we || EN_A !== m_we) errs++;
      if (m_we && (ADDR_A !== 9'(m_addr) || DIN_A !== m_din)) errs++;
      if (count !== 10'(m_count) || full !== (m_count == DEPTH) || empty !== (m_count == 0)) errs++;
      if (ovf_err !== m_ovf || udf_err !== m_udf) errs++;
      total++;
      if (errs != 0)
        $display("[TB] FAIL random%0d: got rdy=%b done=%b we=%b addr=%0d din=%h cnt=%0d ovf=%b udf=%b expected rdy=%b done=%b we=%b addr=%0d din=%h cnt=%0d ovf=%b udf=%b",
                 i, obs_ready, obs_done, WE_A, ADDR_A, DIN_A, count, ovf_err, udf_err,
                 exp_ready, exp_done, m_we, m_addr, m_din, m_count, m_ovf, m_udf);
      else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_write();
    test_full_overflow();
    test_wrap();
    test_same_cycle_and_underflow();
    test_drain();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
